// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access stage: access sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERR,
    RESP
  } state_t;

  // Request attributes kept for the whole transaction.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic [1:0] offset;
  } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the access unit: store enables and replication,
// load right-alignment, and the size/alignment legality check.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shift,
  output logic        misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    be          = 4'b0000;
    wdata_rep   = wdata;
    rdata_shift = rdata;
    misaligned  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be          = 4'b0001 << offset;
        wdata_rep   = {4{wdata[7:0]}};
        rdata_shift = rdata >> {offset, 3'b000};
      end
      SZ_HALF: begin
        be          = 4'b0011 << offset;
        wdata_rep   = {2{wdata[15:0]}};
        rdata_shift = rdata >> {offset[1], 4'b0000};
        misaligned  = offset[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |offset;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store at a time over a valid/ready word bus,
// with misalignment detection, bus timeout and pipeline stall.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_t             state, state_next;
  req_t               req_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               timeout;
  logic [1:0]         lane_size;
  logic [1:0]         lane_offset;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_rdata;
  logic               lane_misaligned;

  assign accept  = req_valid && req_ready;
  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  // In IDLE the lanes decode the incoming request; afterwards the latched one.
  assign lane_size   = (state == IDLE) ? req_size      : req_q.size;
  assign lane_offset = (state == IDLE) ? req_addr[1:0] : req_q.offset;

  mem_lane_align u_lane_align (
    .size        (lane_size),
    .offset      (lane_offset),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (lane_be),
    .wdata_rep   (lane_wdata),
    .rdata_shift (lane_rdata),
    .misaligned  (lane_misaligned)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = lane_misaligned ? ERR : ISSUE;
      ISSUE: begin
        // A ready on the final counted cycle still completes the access.
        if (mem_ready)    state_next = req_q.write ? RESP : WAIT;
        else if (timeout) state_next = RESP;
      end
      WAIT:    if (mem_rvalid || timeout) state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign mem_valid  = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign stall      = (state == ISSUE) || (state == WAIT) || (state == ERR);
  assign mem_we     = req_q.write;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req_q   <= '{write: req_write, size: req_size, offset: req_addr[1:0]};
      addr_q  <= {req_addr[31:2], 2'b00};
      be_q    <= req_write ? lane_be : 4'b0000;
      wdata_q <= lane_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state_next != state) && (state_next == ISSUE || state_next == WAIT)) begin
      cnt <= '0;
    end else if (state == ISSUE || state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Response fields are loaded only on entry to RESP and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else if (state != RESP && state_next == RESP) begin
      resp_misaligned <= (state == ERR);
      resp_fault      <= ((state == ISSUE) && !mem_ready) || ((state == WAIT) && !mem_rvalid);
      resp_rdata      <= ((state == WAIT) && mem_rvalid) ? lane_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses, a bus slave with
// configurable wait states, timeouts, mid-transaction reset and back-to-back traffic.
module tb_mem_access_unit;

  localparam int NEVER = 100;

  typedef struct {
    logic [31:0] rdata;
    bit          mis;
    bit          fault;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    int          rw;
    int          vw;
    bit          early;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_fault, stall;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] bus_mem [0:1023];
  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_exp   = 0;
  int          resp_seen = 0;
  int          stall_cnt = 0;
  int          cyc = 0;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault),
    .stall           (stall),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bus slave: waits rw cycles before ready, then vw cycles before read data.
  initial begin : responder
    bus_t cur;
    int   ph;
    int   cnt;
    bit   spurious;
    ph = 0; cnt = 0; spurious = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cur = '{rw: 0, vw: NEVER, early: 1'b0, addr: '0, we: 1'b0, be: '0, wdata: '0};
    forever begin
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (ph == 2) begin
        if (cur.vw >= NEVER) ph = 0;
        else if (cnt == cur.vw) begin
          mem_rvalid = 1'b1;
          mem_rdata  = bus_mem[cur.addr[11:2]];
          ph = 0;
        end else cnt++;
      end else if (mem_valid) begin
        if (ph == 0) begin
          if (bus_q.size() == 0) begin
            check("unexpected_bus_request", 32'd1, 32'd0);
            spurious = 1'b1;
            cur = '{rw: 0, vw: NEVER, early: 1'b0, addr: '0, we: 1'b0, be: '0, wdata: '0};
          end else begin
            spurious = 1'b0;
            cur = bus_q.pop_front();
          end
          ph = 1; cnt = 0;
        end
        if (cnt == cur.rw) begin
          mem_ready = 1'b1;
          if (!spurious) begin
            check("mem_addr", mem_addr, cur.addr);
            check("mem_we", 32'(mem_we), 32'(cur.we));
            check("mem_be", 32'(mem_be), 32'(cur.be));
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          end
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) bus_mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          if (cur.early) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
          end
          ph = mem_we ? 0 : 2;
          cnt = 0;
        end else cnt++;
      end else ph = 0;
    end
  end

  // Scoreboard monitor: compares each completion with the oldest expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) stall_cnt = 0;
      else begin
        if (resp_valid) begin
          resp_seen++;
          if (exp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_misaligned", 32'(resp_misaligned), 32'(e.mis));
            check("resp_fault", 32'(resp_fault), 32'(e.fault));
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("stall_cycles", 32'(stall_cnt), 32'(e.lat - 1));
          end
          stall_cnt = 0;
        end
        if (stall) stall_cnt++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 the cycle after acceptance.
  task automatic issue(input bit we, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input int rw, input int vw, input bit early,
                       input logic [3:0] be, input logic [31:0] bwd, input logic [31:0] rd,
                       input bit mis, input bit flt, input int lat, input bit track);
    int budget;
    req_valid = 1'b1; req_write = we; req_size = sz; req_addr = addr; req_wdata = wd;
    budget = 0;
    while (!req_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (!mis)
      bus_q.push_back('{rw: rw, vw: vw, early: early, addr: {addr[31:2], 2'b00},
                        we: we, be: be, wdata: bwd});
    if (track) begin
      exp_q.push_back('{rdata: rd, mis: mis, fault: flt, lat: lat, acc: cyc});
      n_exp++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || !req_ready) && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0 || !req_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},
          32'({req_ready, resp_valid, stall, mem_valid, mem_we, resp_misaligned, resp_fault}),
          32'h40);
    check({tag, "_bus"}, mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
    check({tag, "_rdata"}, resp_rdata, 32'h0);
  endtask

  initial begin : stimulus
    int rw, vw;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) bus_mem[i] = 32'h0;
    bus_mem[32'h100 >> 2] = 32'hA1B2_C3D4;
    bus_mem[32'h200 >> 2] = 32'h1122_3344;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    //     we  sz     addr          wdata         rw     vw     early be       bwdata        rdata         mis  flt lat trk
    issue(0, 2'b00, 32'h0000_0103, 32'h0,        0,     0,     0,    4'b0000, 32'h0,        32'h0000_00A1, 0,  0,  3,  1);
    issue(1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 0,    0,     0,    4'b1100, 32'hBEEF_BEEF, 32'h0,        0,  0,  2,  1);
    issue(0, 2'b10, 32'h0000_0301, 32'h0,        0,     0,     0,    4'b0000, 32'h0,        32'h0,        1,  0,  2,  1);
    issue(0, 2'b11, 32'h0000_0300, 32'h0,        0,     0,     0,    4'b0000, 32'h0,        32'h0,        1,  0,  2,  1);
    issue(1, 2'b01, 32'h0000_0205, 32'h0000_1111, 0,    0,     0,    4'b0000, 32'h0,        32'h0,        1,  0,  2,  1);
    issue(0, 2'b01, 32'h0000_0202, 32'h0,        2,     1,     0,    4'b0000, 32'h0,        32'h0000_BEEF, 0,  0,  6,  1);
    issue(0, 2'b10, 32'h0000_0200, 32'h0,        0,     0,     1,    4'b0000, 32'h0,        32'hBEEF_3344, 0,  0,  3,  1);
    issue(0, 2'b00, 32'h0000_0201, 32'h0,        1,     3,     0,    4'b0000, 32'h0,        32'h00BE_EF33, 0,  0,  7,  1);
    issue(1, 2'b00, 32'h0000_0101, 32'h0000_005A, 0,    0,     0,    4'b0010, 32'h5A5A_5A5A, 32'h0,        0,  0,  2,  1);
    issue(0, 2'b00, 32'h0000_0101, 32'h0,        0,     0,     0,    4'b0000, 32'h0,        32'h00A1_B25A, 0,  0,  3,  1);
    issue(1, 2'b10, 32'h0000_0104, 32'hCAFE_F00D, 3,    0,     0,    4'b1111, 32'hCAFE_F00D, 32'h0,        0,  0,  5,  1);
    issue(0, 2'b10, 32'h0000_0104, 32'h0,        0,     2,     0,    4'b0000, 32'h0,        32'hCAFE_F00D, 0,  0,  5,  1);
    issue(0, 2'b01, 32'h0000_0106, 32'h0,        0,     0,     0,    4'b0000, 32'h0,        32'h0000_CAFE, 0,  0,  3,  1);
    // Timeout in ISSUE, ready on the last counted cycle, timeout in WAIT.
    issue(0, 2'b10, 32'h0000_0040, 32'h0,        NEVER, 0,     0,    4'b0000, 32'h0,        32'h0,        0,  1,  17, 1);
    issue(1, 2'b10, 32'h0000_0044, 32'h1234_5678, 15,   0,     0,    4'b1111, 32'h1234_5678, 32'h0,        0,  0,  17, 1);
    issue(0, 2'b10, 32'h0000_0048, 32'h0,        0,     NEVER, 0,    4'b0000, 32'h0,        32'h0,        0,  1,  18, 1);
    wait_idle();

    // Reset while waiting for read data; the late rvalid must not complete anything.
    issue(0, 2'b10, 32'h0000_0100, 32'h0,        0,     5,     0,    4'b0000, 32'h0,        32'h0,        0,  0,  0,  0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Back-to-back traffic with random bus wait states.
    rw = int'($urandom_range(0, 5));
    issue(1, 2'b00, 32'h0000_03C3, 32'h0000_0077, rw, 0, 0, 4'b1000, 32'h7777_7777, 32'h0, 0, 0, 2 + rw, 1);
    rw = int'($urandom_range(0, 5)); vw = int'($urandom_range(0, 5));
    issue(0, 2'b00, 32'h0000_03C3, 32'h0, rw, vw, 0, 4'b0000, 32'h0, 32'h0000_0077, 0, 0, 3 + rw + vw, 1);
    rw = int'($urandom_range(0, 5));
    issue(1, 2'b01, 32'h0000_03C0, 32'hAAAA_1234, rw, 0, 0, 4'b0011, 32'h1234_1234, 32'h0, 0, 0, 2 + rw, 1);
    rw = int'($urandom_range(0, 5)); vw = int'($urandom_range(0, 5));
    issue(0, 2'b10, 32'h0000_03C0, 32'h0, rw, vw, 0, 4'b0000, 32'h0, 32'h7700_1234, 0, 0, 3 + rw + vw, 1);
    rw = int'($urandom_range(0, 5)); vw = int'($urandom_range(0, 5));
    issue(0, 2'b01, 32'h0000_03C2, 32'h0, rw, vw, 0, 4'b0000, 32'h0, 32'h0000_7700, 0, 0, 3 + rw + vw, 1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    check("resp_count", 32'(resp_seen), 32'(n_exp));
    check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage between the execute/memory pipeline stage and the load sign/zero-extension decoder.
- Accepts one load or store request at a time and drives a word-addressed data-memory bus with a valid/ready handshake.
- Generates store byte enables and replicated write data; shifts load data so the addressed byte or halfword sits at bit 0 for the extension decoder.
- Detects misaligned accesses and bus timeouts, and holds the pipeline stall while busy.

Parameters:
- TIMEOUT, 16, max cycles waiting on mem_ready or mem_rvalid before a bus fault is reported; minimum 2.
- CNT_W, 5, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal (funct3[1:0])
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data shifted to bit 0, unextended; feeds decoder ReadData
- resp_misaligned  out  1  qualifies resp_valid: alignment or size error
- resp_fault  out  1  qualifies resp_valid: bus timeout
- stall  out  1  high from acceptance until resp_valid inclusive-minus-one (i.e. while state != IDLE and != RESP)
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_we  out  1  bus write
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables (stores); 4'b0000 on loads
- mem_wdata  out  32  replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- Reset (async): state IDLE; req_ready 1; all other outputs 0; timeout counter 0. Reset mid-transaction abandons it immediately: mem_valid drops in the same instant, no response is generated.
- Request accepted when req_valid && req_ready; write, size, addr[1:0], word address, wdata latched on that edge.
- States:
  - IDLE: req_ready=1. On accept: to ERR if misaligned, else ISSUE.
  - ISSUE: mem_valid=1, bus fields stable from latched values. On mem_ready: store -> RESP; load -> WAIT.
  - WAIT: waits for mem_rvalid; captures the shifted word; -> RESP. mem_rvalid arriving in the same cycle as mem_ready is not legal for the bus; a value there is ignored.
  - ERR: -> RESP with resp_misaligned=1.
  - RESP: resp_valid=1 for exactly one cycle; -> IDLE.
- Misaligned: size 01 with addr[0]=1; size 10 with addr[1:0]!=0; size 11 always. No bus transaction is issued; resp_rdata=0.
- Timeout: counter clears on entry to ISSUE and on entry to WAIT, and increments each cycle in those states. When it reaches TIMEOUT: mem_valid drops, -> RESP with resp_fault=1, resp_rdata=0. mem_ready on the timeout cycle wins; no fault is reported.
- Load shift: resp_rdata = mem_rdata >> (8*addr[1:0]) for bytes; mem_rdata >> (16*addr[1]) for halfwords; unshifted for words. Upper bits are passed as shifted (the decoder masks/extends).
- Store data: byte {4{wdata[7:0]}}, mem_be = 4'b0001 << addr[1:0]; half {2{wdata[15:0]}}, mem_be = 4'b0011 << addr[1:0]; word wdata, mem_be = 4'b1111.
- Latency:
  - Store with zero-wait bus: accept -> ISSUE (mem_ready) -> RESP, so resp_valid 2 cycles after acceptance.
  - Load: ISSUE -> WAIT -> RESP, minimum 3 cycles.
  - Misaligned: 2 cycles.
- Back-to-back: a new request can be accepted the cycle after RESP (IDLE). No overlapping transactions.
- resp_* outputs hold their values outside RESP but are meaningful only with resp_valid.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum (IDLE, ISSUE, WAIT, ERR, RESP).
- One combinational sub-module, mem_lane_align: computes mem_be, replicated wdata, shifted rdata and the misaligned flag from size/addr[1:0]. The FSM stays in the top module.

Test Plan:
- Load byte, addr 0x103, mem_rdata 0xA1B2C3D4, 1-cycle ready + 1-cycle rvalid -> mem_addr 0x100, mem_be 0000, resp_rdata[7:0]=0xA1, resp_valid 3 cycles after accept, stall high 2 cycles.
- Store half, addr 0x202, wdata 0x0000BEEF -> mem_be 1100, mem_wdata 0xBEEFBEEF, mem_we 1; resp_valid 2 cycles after accept with zero-wait mem_ready.
- Load word, addr 0x301 -> no mem_valid ever, resp_misaligned=1, resp_rdata=0, resp_valid 2 cycles after accept; req_size=11 at aligned addr -> same.
- mem_ready held low 16 cycles -> mem_valid drops, resp_fault=1; repeat with mem_ready on cycle 16 -> no fault.
- Assert rst while in WAIT -> all outputs 0, req_ready 1 without a clock edge; a late mem_rvalid produces no resp_valid.
- Back-to-back store then load with random bus wait states (0-5) -> each accepted only in IDLE, exactly one resp_valid per request, data matches a memory model.
